// File: rtl/mem_ddr_tile_resp_pkg.sv
// Shared memory-bus definitions for the DDR-side tile responder (opcodes, status codes).
package mem_ddr_tile_resp_pkg;

  localparam logic [4:0] UMEM_OPM_READY   = 5'h00;
  localparam logic [4:0] UMEM_OPM_RD_TILE = 5'h12;
  localparam logic [4:0] UMEM_OPM_WR_TILE = 5'h13;

  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;

  localparam logic [127:0] UV128_XX = 'x;

  // Byte-lane write enable for a 64-bit beat landing in one tile half.
  function automatic logic [1:0] halfWe(input logic upperHalf);
    return upperHalf ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_tile_bram.sv
// Single-port 2^ADDR_BITS x 128 tile array with per-64-bit-half write enables.
module mem_tile_bram #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clock,
  input  logic                 en_i,
  input  logic [1:0]           we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [127:0]         din_i,
  output logic [127:0]         dout_o
);

  logic [127:0] mem [0:(2**ADDR_BITS)-1];
  logic [127:0] dout_q;

  // Read-first-free port: a write cycle leaves the read register untouched.
  always_ff @(posedge clock) begin
    if (en_i) begin
      if (we_i[0]) mem[addr_i][63:0]   <= din_i[63:0];
      if (we_i[1]) mem[addr_i][127:64] <= din_i[127:64];
      if (we_i == 2'b00) dout_q <= mem[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/mem_ddr_tile_resp.sv
// DDR-side tile responder: serves OPM/OK tile requests after LATENCY HOLD cycles.
// Optional macro JX2_DDR_BL64B_EN switches to 64-bit beats selected by memAddr[3].
module mem_ddr_tile_resp
  import mem_ddr_tile_resp_pkg::*;
#(
  parameter int ADDR_BITS = 14,
  parameter int LATENCY   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  memAddr,
  input  logic [4:0]   memOpm,
  input  logic [127:0] memDataIn,
  output logic [127:0] memDataOut,
  output logic [1:0]   memOK
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] LatCnt = 8'(LATENCY);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   half_q, half_d;
  logic [4:0]             opm_q, opm_d;
  logic [127:0]           wdata_q, wdata_d;
  logic [127:0]           rdata_q, rdata_d;
  logic [1:0]             ok_q, ok_d;

  logic                   ramEn;
  logic [1:0]             ramWe;
  logic [ADDR_BITS-1:0]   ramAddr;
  logic [127:0]           ramDin, ramDout;
  logic [127:0]           readBeat, writeBeat;
  logic [1:0]             writeEn;
  logic                   unusedBits;

`ifdef JX2_DDR_BL64B_EN
  assign readBeat   = {64'b0, (half_q ? ramDout[127:64] : ramDout[63:0])};
  assign writeBeat  = {64'b0, wdata_q[63:0]};
  assign writeEn    = halfWe(half_q);
  assign ramDin     = {wdata_q[63:0], wdata_q[63:0]};
  assign unusedBits = ^{memAddr[31:ADDR_BITS+4], memAddr[2:0], wdata_q[127:64]};
`else
  assign readBeat   = ramDout;
  assign writeBeat  = wdata_q;
  assign writeEn    = 2'b11;
  assign ramDin     = wdata_q;
  assign unusedBits = ^{memAddr[31:ADDR_BITS+4], memAddr[3:0], half_q};
`endif

  mem_tile_bram #(.ADDR_BITS(ADDR_BITS)) u_bram (
    .clock  (clock),
    .en_i   (ramEn),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .din_i  (ramDin),
    .dout_o (ramDout)
  );

  // The array read is launched on the capture edge so the registered BRAM
  // output is already valid when the commit edge arrives, even at LATENCY=1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    half_d  = half_q;
    opm_d   = opm_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ok_d    = ok_q;
    ramEn   = 1'b0;
    ramWe   = 2'b00;
    ramAddr = memAddr[ADDR_BITS+3:4];
    case (state_q)
      IDLE: begin
        ok_d = UMEM_OK_READY;
        if (memOpm != UMEM_OPM_READY) begin
          addr_d  = memAddr[ADDR_BITS+3:4];
          half_d  = memAddr[3];
          opm_d   = memOpm;
          wdata_d = memDataIn;
          ok_d    = UMEM_OK_HOLD;
          cnt_d   = LatCnt;
          ramEn   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d   = cnt_q - 8'd1;
        ramAddr = addr_q;
        if (cnt_q == 8'd1) begin
          ok_d    = UMEM_OK_OK;
          state_d = DONE;
          case (opm_q)
            UMEM_OPM_RD_TILE: rdata_d = readBeat;
            UMEM_OPM_WR_TILE: begin
              ramEn   = 1'b1;
              ramWe   = writeEn;
              rdata_d = writeBeat;
            end
            default: rdata_d = '0;
          endcase
        end
      end
      DONE: begin
        if (memOpm == UMEM_OPM_READY) begin
          ok_d    = UMEM_OK_READY;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      half_q  <= 1'b0;
      opm_q   <= UMEM_OPM_READY;
      wdata_q <= '0;
      rdata_q <= '0;
      ok_q    <= UMEM_OK_READY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      opm_q   <= opm_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ok_q    <= ok_d;
    end
  end

  assign memDataOut = rdata_q;
  assign memOK      = ok_q;

endmodule

// File: tb/tb_mem_ddr_tile_resp.sv
// Directed self-checking bench for mem_ddr_tile_resp (LATENCY=4 and LATENCY=1 instances, ADDR_BITS=4).
module tb_mem_ddr_tile_resp;
  import mem_ddr_tile_resp_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addr0 = '0, addr1 = '0;
  logic [4:0]   opm0 = UMEM_OPM_READY, opm1 = UMEM_OPM_READY;
  logic [127:0] din0 = '0, din1 = '0;
  logic [127:0] dout0, dout1;
  logic [1:0]   ok0, ok1;

  int passCnt = 0;
  int totalCnt = 0;

  localparam logic [127:0] D1   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] DAA  = {16{8'hAA}};
  localparam logic [127:0] DBB  = {16{8'hBB}};
  localparam logic [127:0] DOLD = 128'h0DDC0FFEE0DDC0FF_EE0DDC0FFEE12345;
  localparam logic [127:0] DNEW = 128'h5555AAAA5555AAAA_5555AAAA5555AAAA;
  localparam logic [127:0] D3   = 128'hCAFEBABE12345678_9ABCDEF011223344;
  localparam logic [127:0] D11  = {16{8'h11}};
  localparam logic [127:0] D22  = {16{8'h22}};

  mem_ddr_tile_resp #(.ADDR_BITS(4), .LATENCY(4)) dut (
    .clock(clock), .reset(reset), .memAddr(addr0), .memOpm(opm0),
    .memDataIn(din0), .memDataOut(dout0), .memOK(ok0)
  );

  mem_ddr_tile_resp #(.ADDR_BITS(4), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .memAddr(addr1), .memOpm(opm1),
    .memDataIn(din1), .memDataOut(dout1), .memOK(ok1)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] beat(input logic [127:0] d);
`ifdef JX2_DDR_BL64B_EN
    return {64'b0, d[63:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic [1:0] okOf(input int sel);
    return (sel == 0) ? ok0 : ok1;
  endfunction

  function automatic logic [127:0] dataOf(input int sel);
    return (sel == 0) ? dout0 : dout1;
  endfunction

  task automatic setIn(input int sel, input logic [4:0] o, input logic [31:0] a, input logic [127:0] d);
    if (sel == 0) begin opm0 = o; addr0 = a; din0 = d; end
    else begin opm1 = o; addr1 = a; din1 = d; end
  endtask

  // Issues one request, scrambles addr/data while busy, counts HOLD cycles,
  // optionally keeps opm asserted after OK, then releases and samples memOK.
  task automatic runReq(input int sel, input logic [4:0] o, input logic [31:0] a,
                        input logic [127:0] d, input int holdAfter,
                        output int holdCnt, output logic [127:0] rdata,
                        output logic [1:0] okAfter, output bit stableOk, output bit timedOut);
    setIn(sel, o, a, d);
    @(negedge clock);
    setIn(sel, o, ~a, ~d);
    holdCnt = 0;
    while (okOf(sel) == UMEM_OK_HOLD && holdCnt < 300) begin
      holdCnt++;
      @(negedge clock);
    end
    timedOut = (okOf(sel) != UMEM_OK_OK);
    rdata = dataOf(sel);
    stableOk = 1'b1;
    repeat (holdAfter) begin
      @(negedge clock);
      if (okOf(sel) != UMEM_OK_OK || dataOf(sel) !== rdata) stableOk = 1'b0;
    end
    setIn(sel, UMEM_OPM_READY, 32'h0, 128'h0);
    @(negedge clock);
    okAfter = okOf(sel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    totalCnt++; if (ok0 !== UMEM_OK_READY) $display("[TB] FAIL reset_ok0: got %0h want %0h", ok0, UMEM_OK_READY); else passCnt++;
    totalCnt++; if (dout0 !== 128'h0) $display("[TB] FAIL reset_data0: got %h want 0", dout0); else passCnt++;
    totalCnt++; if (ok1 !== UMEM_OK_READY) $display("[TB] FAIL reset_ok1: got %0h want %0h", ok1, UMEM_OK_READY); else passCnt++;
    totalCnt++; if (dout1 !== 128'h0) $display("[TB] FAIL reset_data1: got %h want 0", dout1); else passCnt++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(0, UMEM_OPM_WR_TILE, 32'h0001_0020, D1, 0, h, r, oa, st, to);
    totalCnt++; if (h !== 4 || to) $display("[TB] FAIL wr_hold: got %0d (timeout %0d) want 4", h, to); else passCnt++;
    totalCnt++; if (r !== beat(D1)) $display("[TB] FAIL wr_data: got %h want %h", r, beat(D1)); else passCnt++;
    totalCnt++; if (oa !== UMEM_OK_READY) $display("[TB] FAIL wr_release: got %0h want %0h", oa, UMEM_OK_READY); else passCnt++;
    runReq(0, UMEM_OPM_RD_TILE, 32'h0001_0020, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (h !== 4 || to) $display("[TB] FAIL rd_hold: got %0d (timeout %0d) want 4", h, to); else passCnt++;
    totalCnt++; if (r !== beat(D1)) $display("[TB] FAIL rd_data: got %h want %h", r, beat(D1)); else passCnt++;
  endtask

  task automatic test_hold_after_ok();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(0, UMEM_OPM_RD_TILE, 32'h0001_0020, 128'h0, 10, h, r, oa, st, to);
    totalCnt++; if (!st || to) $display("[TB] FAIL hold_stable: got stable=%0d timeout=%0d want 1/0", st, to); else passCnt++;
    totalCnt++; if (r !== beat(D1)) $display("[TB] FAIL hold_data: got %h want %h", r, beat(D1)); else passCnt++;
    totalCnt++; if (oa !== UMEM_OK_READY) $display("[TB] FAIL hold_release: got %0h want %0h", oa, UMEM_OK_READY); else passCnt++;
  endtask

  task automatic test_alias();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(0, UMEM_OPM_WR_TILE, 32'h0000_0010, DAA, 0, h, r, oa, st, to);
    runReq(0, UMEM_OPM_WR_TILE, 32'h0000_0110, DBB, 0, h, r, oa, st, to);
    runReq(0, UMEM_OPM_RD_TILE, 32'h0000_0010, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (r !== beat(DBB) || to) $display("[TB] FAIL alias_data: got %h want %h", r, beat(DBB)); else passCnt++;
  endtask

  task automatic test_reset_busy();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(0, UMEM_OPM_WR_TILE, 32'h0000_0040, DOLD, 0, h, r, oa, st, to);
    setIn(0, UMEM_OPM_WR_TILE, 32'h0000_0040, DNEW);
    @(negedge clock);
    @(negedge clock);
    totalCnt++; if (ok0 !== UMEM_OK_HOLD) $display("[TB] FAIL rstbusy_hold: got %0h want %0h", ok0, UMEM_OK_HOLD); else passCnt++;
    reset = 1'b1;
    setIn(0, UMEM_OPM_READY, 32'h0, 128'h0);
    @(negedge clock);
    totalCnt++; if (ok0 !== UMEM_OK_READY) $display("[TB] FAIL rstbusy_ok: got %0h want %0h", ok0, UMEM_OK_READY); else passCnt++;
    reset = 1'b0;
    @(negedge clock);
    runReq(0, UMEM_OPM_RD_TILE, 32'h0000_0040, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (r !== beat(DOLD) || to) $display("[TB] FAIL rstbusy_data: got %h want %h", r, beat(DOLD)); else passCnt++;
  endtask

  task automatic test_back_to_back();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(1, UMEM_OPM_WR_TILE, 32'h0000_0030, D3, 0, h, r, oa, st, to);
    totalCnt++; if (h !== 1 || to) $display("[TB] FAIL b2b_wr_hold: got %0d want 1", h); else passCnt++;
    for (int i = 0; i < 2; i++) begin
      runReq(1, UMEM_OPM_RD_TILE, 32'h0000_0030, 128'h0, 0, h, r, oa, st, to);
      totalCnt++; if (h !== 1 || to) $display("[TB] FAIL b2b_rd_hold%0d: got %0d want 1", i, h); else passCnt++;
      totalCnt++; if (r !== beat(D3)) $display("[TB] FAIL b2b_rd_data%0d: got %h want %h", i, r, beat(D3)); else passCnt++;
      totalCnt++; if (oa !== UMEM_OK_READY) $display("[TB] FAIL b2b_gap%0d: got %0h want %0h", i, oa, UMEM_OK_READY); else passCnt++;
    end
    runReq(1, 5'h1F, 32'h0000_0030, D1, 0, h, r, oa, st, to);
    totalCnt++; if (h !== 1 || to) $display("[TB] FAIL unsup_hold: got %0d want 1", h); else passCnt++;
    totalCnt++; if (r !== 128'h0) $display("[TB] FAIL unsup_data: got %h want 0", r); else passCnt++;
    runReq(1, UMEM_OPM_RD_TILE, 32'h0000_0030, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (r !== beat(D3)) $display("[TB] FAIL unsup_noalter: got %h want %h", r, beat(D3)); else passCnt++;
  endtask

`ifdef JX2_DDR_BL64B_EN
  task automatic test_bl64();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(0, UMEM_OPM_WR_TILE, 32'h0000_0080, D11, 0, h, r, oa, st, to);
    runReq(0, UMEM_OPM_WR_TILE, 32'h0000_0088, D22, 0, h, r, oa, st, to);
    runReq(0, UMEM_OPM_RD_TILE, 32'h0000_0080, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (r !== {64'b0, D11[63:0]}) $display("[TB] FAIL bl64_lo: got %h want %h", r, {64'b0, D11[63:0]}); else passCnt++;
    runReq(0, UMEM_OPM_RD_TILE, 32'h0000_0088, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (r !== {64'b0, D22[63:0]}) $display("[TB] FAIL bl64_hi: got %h want %h", r, {64'b0, D22[63:0]}); else passCnt++;
  endtask
`else
  task automatic test_low_bits_ignored();
    int h; logic [127:0] r; logic [1:0] oa; bit st, to;
    runReq(0, UMEM_OPM_WR_TILE, 32'h0000_0088, D22, 0, h, r, oa, st, to);
    runReq(0, UMEM_OPM_RD_TILE, 32'h0000_0080, 128'h0, 0, h, r, oa, st, to);
    totalCnt++; if (r !== D22) $display("[TB] FAIL lowbits_data: got %h want %h", r, D22); else passCnt++;
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset();
    test_write_read();
    test_hold_after_ok();
    test_alias();
    test_reset_busy();
    test_back_to_back();
`ifdef JX2_DDR_BL64B_EN
    test_bl64();
`else
    test_low_bits_ignored();
`endif
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_ddr_tile_resp.md
Name: mem_ddr_tile_resp

Overview:
- Tile-memory responder on the DDR side of the L2 tile cache.
- Accepts 128-bit tile read/write requests over the OPM/OK handshake that the L2 drives as initiator.
- Serves them from an internal tile array after a programmable latency.
- Used as the backing-store model for simulation and as a BRAM-backed main memory on small FPGA configurations.

Parameters:
- ADDR_BITS, 14, log2 of tile count; array holds 2^ADDR_BITS 16-byte tiles.
- LATENCY, 4, cycles memOK is HOLD before OK; legal range 1..255.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- memAddr  in  32  byte address; tile index = memAddr[ADDR_BITS+3:4]
- memOpm  in  5  request opcode (UMEM_OPM_*)
- memDataIn  in  128  write tile data
- memDataOut  out  128  read tile data, registered
- memOK  out  2  response status (UMEM_OK_*), registered

Behaviour:
- Clocking: single clock; reset is synchronous and active-high. All state and outputs are registered.
- Reset values:
  - memOK = UMEM_OK_READY
  - memDataOut = 0
  - state = IDLE
  - latency counter = 0
  - Tile array is not cleared.
- Reset mid-operation: any pending access is dropped. A write that has not yet committed is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - memOK = READY.
  - On an edge where memOpm != UMEM_OPM_READY: capture addr, opm and data; memOK <= HOLD; cnt <= LATENCY; go to BUSY.
- BUSY:
  - memOK stays HOLD. memOpm, memAddr and memDataIn are ignored (captured copy is used).
  - Each edge decrements cnt.
  - On the edge where cnt == 1, commit:
    - UMEM_OPM_RD_TILE: memDataOut <= tile[idx].
    - UMEM_OPM_WR_TILE: tile[idx] <= captured data; memDataOut <= captured data.
    - Any other nonzero opm: no array access; memDataOut <= 0.
  - On that same edge: memOK <= OK; go to DONE.
  - HOLD is therefore visible for exactly LATENCY cycles. OK is first visible LATENCY cycles after the capture edge.
- DONE:
  - memOK = OK and memDataOut is held stable while memOpm != READY.
  - On an edge with memOpm == READY: memOK <= READY; go to IDLE.
  - A new request is accepted no earlier than the following edge, so there is at least one READY cycle between requests.
- Address wrap: tile index bits above ADDR_BITS+3 are ignored, so addresses alias modulo 2^ADDR_BITS tiles. memAddr[3:0] is ignored unless the optional feature is enabled.
- Ordering: a write is committed before its OK, so a read issued after a write's OK returns the new data.
- Array: one read-or-write port; only one access per request, so no port conflicts.

Optional Feature:
- Macro: JX2_DDR_BL64B_EN.
- Enabled (64-bit beats):
  - memAddr[3] selects the tile half.
  - Read returns the selected half in memDataOut[63:0], with [127:64] = 0.
  - Write stores memDataIn[63:0] into the selected half only; the other half is preserved (read-modify-write inside the commit cycle, or two 64-bit half arrays).
  - The array is still indexed by memAddr[ADDR_BITS+3:4].
- Disabled: full 128-bit tile per request; memAddr[3:0] ignored.

Decomposition:
- Shared defs file (CoreDefs.v) supplies:
  - UMEM_OPM_READY, UMEM_OPM_RD_TILE, UMEM_OPM_WR_TILE
  - UMEM_OK_READY, UMEM_OK_HOLD, UMEM_OK_OK
  - UV128_XX
- State encodings stay local to the module.
- One sub-module is natural: mem_tile_bram, a single-port 2^ADDR_BITS x 128 array with a per-64-bit-half write enable, so FPGA tools infer block RAM.

Test Plan:
- Write then read back, LATENCY=4:
  - WR_TILE at 0x00010020 with data 0x0123..CDEF → HOLD for 4 cycles, then OK.
  - Initiator drops opm → READY.
  - RD_TILE at 0x00010020 → same data after 4 HOLD cycles.
- Initiator holds opm after OK for 10 cycles → OK and memDataOut stay constant throughout; READY appears one cycle after opm = READY.
- Alias check, ADDR_BITS=4: write 0xAA.. at 0x00000010, write 0xBB.. at 0x00000110 → read at 0x00000010 returns 0xBB...
- Reset asserted during BUSY of a WR_TILE to 0x40 → memOK = READY on the next edge; a later read of 0x40 returns the old contents.
- LATENCY=1 back-to-back reads → exactly one HOLD cycle per request and one READY gap between requests. Unsupported opm → OK with data 0.
- With JX2_DDR_BL64B_EN:
  - Write 0x1111.. at 0x80, then write 0x2222.. at 0x88.
  - Read 0x80 → [63:0] = 0x1111.., [127:64] = 0.
  - Read 0x88 → [63:0] = 0x2222...
